// File: rtl/ddr3_avl_adapter.sv
// Bridges a 64-bit CPU request/response port onto a 96-bit DDR3 Avalon-MM local port.
// One registered command slot, credit-protected read-return FIFO (rdata_valid has no back-pressure).
module ddr3_avl_adapter #(
  parameter int ADDR_WIDTH = 24,
  parameter int RESP_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [63:0]           req_wdata,
  input  logic [7:0]            req_be,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [63:0]           resp_data,
  input  logic                  avl_ready,
  output logic                  avl_burstbegin,
  output logic [ADDR_WIDTH-1:0] avl_addr,
  output logic                  avl_read_req,
  output logic                  avl_write_req,
  output logic [6:0]            avl_size,
  output logic [95:0]           avl_wdata,
  output logic [11:0]           avl_be,
  input  logic                  avl_rdata_valid,
  input  logic [95:0]           avl_rdata
);

  localparam int PTR_W = $clog2(RESP_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic                  cmd_valid_q, cmd_valid_d;
  logic                  cmd_first_q, cmd_first_d;
  logic                  cmd_write_q, cmd_write_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q,  cmd_addr_d;
  logic [63:0]           cmd_wdata_q, cmd_wdata_d;
  logic [7:0]            cmd_be_q,    cmd_be_d;

  logic [CNT_W-1:0]      credits_q, credits_d;
  logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic                  resp_valid_q;
  logic [63:0]           fifo_mem_q [RESP_DEPTH];

  logic accept, rd_accept, push, pop;
  logic unused_rdata_hi;

  assign unused_rdata_hi = ^avl_rdata[95:64];

  // Credit term looks only at the registered count; a same-cycle pop frees the slot next cycle.
  assign req_ready = !reset && (!cmd_valid_q || avl_ready)
                     && (req_write || (credits_q < CNT_W'(RESP_DEPTH)));
  assign accept    = req_valid && req_ready;
  assign rd_accept = accept && !req_write;
  assign push      = avl_rdata_valid;
  assign pop       = resp_valid_q && resp_ready;

  always_comb begin
    cmd_valid_d = cmd_valid_q;
    cmd_first_d = cmd_first_q;
    cmd_write_d = cmd_write_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    cmd_be_d    = cmd_be_q;
    if (accept) begin
      cmd_valid_d = 1'b1;
      cmd_first_d = 1'b1;
      cmd_write_d = req_write;
      cmd_addr_d  = req_addr;
      cmd_wdata_d = req_wdata;
      cmd_be_d    = req_be;
    end else begin
      // burstbegin is a one-cycle marker even while the controller stalls
      if (cmd_valid_q) cmd_first_d = 1'b0;
      if (cmd_valid_q && avl_ready) cmd_valid_d = 1'b0;
    end
  end

  always_comb begin
    credits_d = credits_q;
    case ({rd_accept, pop})
      2'b10:   credits_d = credits_q + CNT_W'(1);
      2'b01:   credits_d = credits_q - CNT_W'(1);
      default: credits_d = credits_q;
    endcase
  end

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_valid_q  <= 1'b0;
      cmd_first_q  <= 1'b0;
      cmd_write_q  <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      cmd_be_q     <= '0;
      credits_q    <= '0;
      fifo_cnt_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      cmd_valid_q  <= cmd_valid_d;
      cmd_first_q  <= cmd_first_d;
      cmd_write_q  <= cmd_write_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      cmd_be_q     <= cmd_be_d;
      credits_q    <= credits_d;
      fifo_cnt_q   <= fifo_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      resp_valid_q <= (fifo_cnt_d != '0);
    end
  end

  // Storage needs no reset; only entries behind the write pointer are ever read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= avl_rdata[63:0];
  end

  assign resp_valid     = resp_valid_q;
  assign resp_data      = fifo_mem_q[rd_ptr_q];
  assign avl_burstbegin = cmd_valid_q && cmd_first_q;
  assign avl_read_req   = cmd_valid_q && !cmd_write_q;
  assign avl_write_req  = cmd_valid_q && cmd_write_q;
  assign avl_addr       = cmd_addr_q;
  assign avl_size       = 7'd1;
  assign avl_wdata      = {32'b0, cmd_wdata_q};
  assign avl_be         = {4'b0, cmd_be_q};

endmodule
